// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//
// General-purpose register file with two combinational read ports, one
// synchronous write port, and a per-register busy scoreboard for in-flight
// producers. Decode issues destinations (setting busy) and checks hazards on
// the read addresses; writeback writes data and clears busy.
//
// Parameters
//   DATA_W   register width in bits
//   DEPTH    number of registers (power of two, >= 2)
//   ZERO_REG 1: register 0 reads 0, is never written, never marked busy
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   we, waddr, wdata     writeback write port; a write also clears busy[waddr]
//   raddr1/2, rdata1/2   combinational read ports
//   issue_valid/rd       issued destination; sets busy[issue_rd]
//   flush                clears every busy bit (issue ignored, write kept)
//   rs1_busy, rs2_busy   busy bit of raddr1 / raddr2 (combinational)
//   busy_count           registered popcount of the busy vector, one cycle
//                        behind the busy bits
//
// Configuration macro
//   REGFILE_BYPASS_EN    when defined, a same-cycle write to a read address is
//                        forwarded to rdataN and its busy bit reads as cleared
//                        (unless the same address is being issued this cycle).
//                        When undefined, reads return the stored state only.
// -----------------------------------------------------------------------------
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr1,
  input  logic [$clog2(DEPTH)-1:0]   raddr2,
  output logic [DATA_W-1:0]          rdata1,
  output logic [DATA_W-1:0]          rdata2,
  input  logic                       issue_valid,
  input  logic [$clog2(DEPTH)-1:0]   issue_rd,
  input  logic                       flush,
  output logic                       rs1_busy,
  output logic                       rs2_busy,
  output logic [$clog2(DEPTH+1)-1:0] busy_count
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam bit HAS_ZERO = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_next;

  // Qualified write / issue: register 0 is neither writable nor settable
  // when it is hard-wired to zero.
  logic wr_ok;
  logic set_ok;

  assign wr_ok  = we && !(HAS_ZERO && (waddr == ADDR_W'(0)));
  assign set_ok = issue_valid && !(HAS_ZERO && (issue_rd == ADDR_W'(0)));

  function automatic logic [CNT_W-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  // Busy update. Clear is applied before set so that a new producer issued
  // to the same register that is writing back keeps the bit set.
  always_comb begin
    busy_next = busy;
    if (flush) begin
      busy_next = '0;
    end else begin
      if (wr_ok) begin
        busy_next[waddr] = 1'b0;
      end
      if (set_ok) begin
        busy_next[issue_rd] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      busy       <= '0;
      busy_count <= '0;
    end else begin
      if (wr_ok) begin
        mem[waddr] <= wdata;
      end
      busy       <= busy_next;
      // Counts the vector as it stood before this edge: one cycle behind.
      busy_count <= popcount(busy);
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Forwarding is suppressed during reset so all read outputs stay at 0.
  logic byp_ok;
  assign byp_ok = wr_ok && rst_n;
`endif

  always_comb begin
    rdata1   = mem[raddr1];
    rs1_busy = busy[raddr1];
`ifdef REGFILE_BYPASS_EN
    if (byp_ok && (waddr == raddr1)) begin
      rdata1   = wdata;
      rs1_busy = set_ok && (issue_rd == raddr1);
    end
`endif
    if (HAS_ZERO && (raddr1 == ADDR_W'(0))) begin
      rdata1   = '0;
      rs1_busy = 1'b0;
    end
  end

  always_comb begin
    rdata2   = mem[raddr2];
    rs2_busy = busy[raddr2];
`ifdef REGFILE_BYPASS_EN
    if (byp_ok && (waddr == raddr2)) begin
      rdata2   = wdata;
      rs2_busy = set_ok && (issue_rd == raddr2);
    end
`endif
    if (HAS_ZERO && (raddr2 == ADDR_W'(0))) begin
      rdata2   = '0;
      rs2_busy = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_regfile_scoreboard
//
// Drives two instances sharing all inputs: dut (ZERO_REG=1) and dut_nz
// (ZERO_REG=0). A behavioural model of both (index 0 = dut, 1 = dut_nz) is
// advanced at each rising edge from the inputs present at that edge. Expected
// values are pushed to exp_q when stimulus is applied and popped when the
// outputs are sampled (1 ns after the inputs settle, away from the edge).
// -----------------------------------------------------------------------------
module tb_regfile_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        flush;

  logic [31:0] rdata1, rdata2, z_rdata1, z_rdata2;
  logic        rs1_busy, rs2_busy, z_rs1_busy, z_rs2_busy;
  logic [5:0]  busy_count, z_busy_count;

  regfile_scoreboard #(.DATA_W(32), .DEPTH(32), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .busy_count(busy_count)
  );

  regfile_scoreboard #(.DATA_W(32), .DEPTH(32), .ZERO_REG(0)) dut_nz (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(z_rdata1), .rdata2(z_rdata2),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
    .rs1_busy(z_rs1_busy), .rs2_busy(z_rs2_busy), .busy_count(z_busy_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model and scoreboard ----------------
  logic [31:0] m_mem [2][32];
  logic [31:0] m_busy [2];
  int          m_cnt [2];
  logic [31:0] exp_q [$];
  logic [31:0] got;
  logic [31:0] exp;
  int          n_checks;
  int          n_pass;

  function automatic bit writable(input int k, input int a);
    return !((k == 0) && (a == 0));
  endfunction

  function automatic logic [31:0] exp_rd(input int k, input int a);
`ifdef REGFILE_BYPASS_EN
    if (rst_n && we && (int'(waddr) == a) && writable(k, a)) return wdata;
`endif
    if (!writable(k, a)) return 32'd0;
    return m_mem[k][a];
  endfunction

  function automatic logic [31:0] exp_busy(input int k, input int a);
`ifdef REGFILE_BYPASS_EN
    if (rst_n && we && (int'(waddr) == a) && writable(k, a))
      return {31'd0, issue_valid && (int'(issue_rd) == a)};
`endif
    if (!writable(k, a)) return 32'd0;
    return {31'd0, m_busy[k][a]};
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) m_mem[k][i] = 32'd0;
      m_busy[k] = 32'd0;
      m_cnt[k]  = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    we = 1'b0; waddr = 5'd0; wdata = 32'd0;
    issue_valid = 1'b0; issue_rd = 5'd0; flush = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    model_clear();
    #3;
    rst_n = 1'b1;
  endtask

  // One rising edge; the model consumes the inputs held across that edge.
  task automatic step();
    logic [31:0] nb;
    int nc;
    bit zr;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      zr = (k == 0);
      nc = 0;
      for (int i = 0; i < 32; i++) nc += int'(m_busy[k][i]);
      nb = m_busy[k];
      if (we && !(zr && waddr == 5'd0)) m_mem[k][waddr] = wdata;
      if (flush) nb = 32'd0;
      else begin
        if (we) nb[waddr] = 1'b0;
        if (issue_valid && !(zr && issue_rd == 5'd0)) nb[issue_rd] = 1'b1;
      end
      m_busy[k] = nb;
      m_cnt[k]  = nc;
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    raddr1 = 5'd1; raddr2 = 5'd2;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    #1;
    got = rdata1; exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) $display("FAIL reset_rdata1: got %h want %h", got, exp); else n_pass++;
    got = 32'(busy_count); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) $display("FAIL reset_count: got %0d want %0d", got, exp); else n_pass++;

    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    step();
    idle(); raddr1 = 5'd5;
    exp_q.push_back(exp_rd(0, 5));
    #1;
    got = rdata1; exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) $display("FAIL preload_x5: got %h want %h", got, exp); else n_pass++;

    // Reset pulse between edges: storage must clear immediately.
    rst_n = 1'b0;
    model_clear();
    exp_q.push_back(exp_rd(0, 5));
    exp_q.push_back(32'd0);
    #1;
    got = rdata1; exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) $display("FAIL midreset_x5: got %h want %h", got, exp); else n_pass++;
    got = 32'(busy_count); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) $display("FAIL midreset_count: got %0d want %0d", got, exp); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_zero_reg();
    do_reset();
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    issue_valid = 1'b1; issue_rd = 5'd0;
    step();
    idle(); raddr1 = 5'd0;
    step();
    exp_q.push_back(exp_rd(0, 0));
    exp_q.push_back(exp_busy(0, 0));
    exp_q.push_back(32'(m_cnt[0]));
    exp_q.push_back(exp_rd(1, 0));
    exp_q.push_back(exp_busy(1, 0));
    exp_q.push_back(32'(m_cnt[1]));
    #1;
    got = rdata1; exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) $display("FAIL zero_rdata: got %h want %h", got, exp); else n_pass++;
    got = 32'(rs1_busy); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) $display("FAIL zero_busy: got %0d want %0d", got, exp); else n_pass++;
    got = 32'(busy_count); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) $display("FAIL zero_count: got %0d want %0d", got, exp); else n_pass++;
    got = z_rdata1; exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) $display("FAIL nz_r0_rdata: got %h want %h", got, exp); else n_pass++;
    got = 32'(z_rs1_busy); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) $display("FAIL nz_r0_busy: got %0d want %0d", got, exp); else n_pass++;
    got = 32'(z_busy_count); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) $display("FAIL nz_r0_count: got %0d want %0d", got, exp); else n_pass++;
  endtask

  task automatic test_scoreboard();
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd3;
    step();
    issue_rd = 5'd7;
    step();
    idle();
    exp_q.push_back(32'(m_cnt[0]));
    #1;
    got = 32'(busy_count); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) $display("FAIL sb_count_a: got %0d want %0d", got, exp); else n_pass++;
    step();
    exp_q.push_back(32'(m_cnt[0]));
    #1;
    got = 32'(busy_count); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) $display("FAIL sb_count_b: got %0d want %0d", got, exp); else n_pass++;

    we = 1'b1; waddr = 5'd3; wdata = 32'h33; raddr1 = 5'd3;
    exp_q.push_back(exp_busy(0, 3));
    #1;
    got = 32'(rs1_busy); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) $display("FAIL sb_x3_during_wr: got %0d want %0d", got, exp); else n_pass++;
    step();
    idle(); raddr1 = 5'd3;
    step();
    exp_q.push_back(exp_busy(0, 3));
    exp_q.push_back(32'(m_cnt[0]));
    #1;
    got = 32'(rs1_busy); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) $display("FAIL sb_x3_cleared: got %0d want %0d", got, exp); else n_pass++;
    got = 32'(busy_count); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) $display("FAIL sb_count_c: got %0d want %0d", got, exp); else n_pass++;

    // Issue and writeback of x7 in the same cycle: set wins.
    we = 1'b1; waddr = 5'd7; wdata = 32'h77; issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    idle(); raddr1 = 5'd7;
    exp_q.push_back(exp_busy(0, 7));
    #1;
    got = 32'(rs1_busy); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) $display("FAIL sb_x7_set_wins: got %0d want %0d", got, exp); else n_pass++;
  endtask

  task automatic test_flush();
    do_reset();
    issue_valid = 1'b1;
    issue_rd = 5'd1; step();
    issue_rd = 5'd2; step();
    issue_rd = 5'd4; step();
    issue_rd = 5'd9; flush = 1'b1;
    we = 1'b1; waddr = 5'd12; wdata = 32'h0000ABCD;
    step();
    idle(); raddr1 = 5'd9; raddr2 = 5'd1;
    step();
    exp_q.push_back(exp_busy(0, 9));
    exp_q.push_back(exp_busy(0, 1));
    exp_q.push_back(32'(m_cnt[0]));
    #1;
    got = 32'(rs1_busy); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) $display("FAIL flush_x9: got %0d want %0d", got, exp); else n_pass++;
    got = 32'(rs2_busy); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) $display("FAIL flush_x1: got %0d want %0d", got, exp); else n_pass++;
    got = 32'(busy_count); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) $display("FAIL flush_count: got %0d want %0d", got, exp); else n_pass++;
    raddr1 = 5'd12;
    exp_q.push_back(exp_rd(0, 12));
    #1;
    got = rdata1; exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) $display("FAIL flush_write_kept: got %h want %h", got, exp); else n_pass++;
  endtask

  task automatic test_bypass();
    do_reset();
    we = 1'b1; waddr = 5'd10; wdata = 32'h5555; issue_valid = 1'b1; issue_rd = 5'd10;
    step();
    idle();
    we = 1'b1; waddr = 5'd10; wdata = 32'h1234; raddr2 = 5'd10;
    exp_q.push_back(exp_rd(0, 10));
    exp_q.push_back(exp_busy(0, 10));
    #1;
    got = rdata2; exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) $display("FAIL bypass_same_cycle_rd: got %h want %h", got, exp); else n_pass++;
    got = 32'(rs2_busy); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) $display("FAIL bypass_same_cycle_busy: got %0d want %0d", got, exp); else n_pass++;
    step();
    idle(); raddr2 = 5'd10;
    exp_q.push_back(32'h1234);
    exp_q.push_back(32'd0);
    #1;
    got = rdata2; exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) $display("FAIL bypass_next_rd: got %h want %h", got, exp); else n_pass++;
    got = 32'(rs2_busy); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) $display("FAIL bypass_next_busy: got %0d want %0d", got, exp); else n_pass++;
  endtask

  task automatic test_full();
    int a;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      issue_valid = 1'b1; issue_rd = 5'(i);
      step();
    end
    idle();
    step();
    exp_q.push_back(32'(m_cnt[1]));
    exp_q.push_back(32'(m_cnt[0]));
    #1;
    got = 32'(z_busy_count); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp || got !== 32'd32) $display("FAIL full_count_nz: got %0d want %0d", got, exp); else n_pass++;
    got = 32'(busy_count); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp || got !== 32'd31) $display("FAIL full_count_zr: got %0d want %0d", got, exp); else n_pass++;
    for (int i = 0; i < 32; i++) begin
      we = 1'b1; waddr = 5'(i); wdata = $urandom();
      step();
    end
    idle();
    step();
    a = $urandom_range(0, 31);
    raddr1 = 5'(a);
    exp_q.push_back(32'(m_cnt[1]));
    exp_q.push_back(32'(m_cnt[0]));
    exp_q.push_back(exp_rd(1, a));
    #1;
    got = 32'(z_busy_count); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) $display("FAIL drain_count_nz: got %0d want %0d", got, exp); else n_pass++;
    got = 32'(busy_count); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) $display("FAIL drain_count_zr: got %0d want %0d", got, exp); else n_pass++;
    got = z_rdata1; exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) $display("FAIL drain_rdata_nz: got %h want %h", got, exp); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 60; c++) begin
      we = 1'($urandom_range(0, 1));
      waddr = 5'($urandom_range(0, 31));
      wdata = $urandom();
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      flush = ($urandom_range(0, 15) == 0);
      raddr1 = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom_range(0, 31));
      raddr2 = 5'($urandom_range(0, 31));
      exp_q.push_back(exp_rd(0, int'(raddr1)));
      exp_q.push_back(exp_rd(0, int'(raddr2)));
      exp_q.push_back(exp_busy(0, int'(raddr1)));
      exp_q.push_back(exp_busy(1, int'(raddr2)));
      exp_q.push_back(32'(m_cnt[0]));
      exp_q.push_back(32'(m_cnt[1]));
      #1;
      got = rdata1; exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) $display("FAIL b2b_rdata1 c%0d: got %h want %h", c, got, exp); else n_pass++;
      got = rdata2; exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) $display("FAIL b2b_rdata2 c%0d: got %h want %h", c, got, exp); else n_pass++;
      got = 32'(rs1_busy); exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) $display("FAIL b2b_rs1_busy c%0d: got %0d want %0d", c, got, exp); else n_pass++;
      got = 32'(z_rs2_busy); exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) $display("FAIL b2b_nz_rs2_busy c%0d: got %0d want %0d", c, got, exp); else n_pass++;
      got = 32'(busy_count); exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) $display("FAIL b2b_count c%0d: got %0d want %0d", c, got, exp); else n_pass++;
      got = 32'(z_busy_count); exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) $display("FAIL b2b_nz_count c%0d: got %0d want %0d", c, got, exp); else n_pass++;
      step();
    end
    idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n  = 1'b0;
    raddr1 = 5'd0;
    raddr2 = 5'd0;
    idle();
    test_reset();
    test_zero_reg();
    test_scoreboard();
    test_flush();
    test_bypass();
    test_full();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
